de2_115_sma_pulse_gen: RTL and testbench
========================================

Name: de2_115_sma_pulse_gen

Overview:
- Avalon-MM slave that generates a programmable pulse train on the SMA output connector. It supersedes the plain single-bit PIO drive for that pin.
- The CPU programs period, high time and pulse count, then starts the generator. The block produces cycle-exact pulses and raises a sticky done flag and an optional IRQ on completion.
- It sits between the system interconnect and the SMA pin.

Parameters:
- CNT_W, 32, width of the PERIOD and HIGH registers and of the phase counter.
- PCNT_W, 16, width of the COUNT register and of the pulse counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word address of the register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address (zero wait, zero latency), unused bits 0
- irq  out  1  level interrupt = DONE & CTRL.IRQ_EN
- sma_out  out  1  registered pulse output to the SMA connector

Behaviour:
- Clock and reset: clk is the clock. reset_n is asynchronous, active-low. Every register, counter and output clears to 0, state = IDLE, sma_out = 0.
- Register map (a write occurs when chipselect && !write_n):
  - 0 CTRL: bit0 RUN, bit1 CONT (continuous), bit2 POL (1 = inverted output), bit3 IRQ_EN. Reads return RUN = busy, plus the stored bits 3:1.
  - 1 PERIOD: clocks per pulse. Values below 2 are treated as 2.
  - 2 HIGH: active clocks per pulse. 0 gives a constant inactive level. A value >= effective period gives a constant active level.
  - 3 COUNT: number of pulses in one-shot mode (CONT = 0).
  - 4 STATUS: bit0 BUSY, bit1 DONE (sticky; writing 1 to bit1 clears it), bits [16+PCNT_W-1:16] remaining pulses.
  - 5–7: reads return 0, writes are ignored.
- State machine:
  - States are IDLE and RUN.
  - IDLE -> RUN: a CTRL write with bit0 = 1. PERIOD and HIGH are copied into shadow registers, the phase counter is set to 0, and the pulse counter is loaded from COUNT.
  - RUN -> IDLE on stop: a CTRL write with bit0 = 0. This takes effect at that edge. sma_out returns to the idle level (POL) in the next cycle. DONE is not set.
  - RUN -> IDLE on completion: in one-shot mode, when the last pulse's period ends. DONE is set on the same edge.
  - A CTRL write with bit0 = 1 while in RUN updates CONT, POL and IRQ_EN only. It does not restart the generator.
- Output timing:
  - sma_out = POL XOR (RUN && phase < HIGH_shadow), registered.
  - The first active cycle is the cycle immediately after the write cycle that starts the generator.
  - The high time is exactly HIGH_shadow clocks. The period is exactly the effective period in clocks, with no gap between pulses.
- Phase and pulse counting:
  - The phase counter increments each clock and wraps from (effective period − 1) to 0.
  - On each wrap, the shadow registers reload from PERIOD and HIGH. CPU writes during RUN therefore take effect at the next pulse boundary, never mid-pulse.
  - In one-shot mode the pulse counter decrements on each wrap. A wrap with pulse counter == 1 ends the run.
  - In continuous mode the pulse counter is frozen and the generator runs until stopped.
- COUNT = 0 with CONT = 0: no pulse is produced, BUSY stays 0, and DONE is set one clock after the start write.
- Simultaneous events:
  - Completion and a DONE-clear write in the same cycle: set wins and DONE = 1.
  - A stop write on the completion edge: stop wins and DONE is not set.
- Reset mid-run: sma_out goes to 0 immediately (asynchronously), even when POL = 1. After reset, POL = 0.

Test Plan:
- Reset check: assert reset_n = 0 mid-run -> sma_out, irq, readdata for every address, and BUSY all read 0.
- One-shot: PERIOD = 10, HIGH = 3, COUNT = 4, write CTRL = 0x9 -> four pulses of 3 high / 7 low. The first high is in the cycle after the write. BUSY drops and DONE and irq rise exactly 40 clocks after the first high. STATUS reads 0x2.
- Continuous with live update: CONT = 1, PERIOD = 4, HIGH = 2; write PERIOD = 8 mid-pulse -> the current pulse completes at 4 clocks, and the next pulses are 2 high / 6 low. Write CTRL = 0 -> sma_out = 0 the next cycle, DONE stays 0.
- Edge values:
  - PERIOD = 0, HIGH = 1 -> 1 high / 1 low.
  - HIGH = 0 -> sma_out constant 0.
  - HIGH = 20 with PERIOD = 5 -> constant 1 for COUNT × 5 clocks.
  - COUNT = 0 -> no pulse, DONE = 1 after 1 clock.
- Polarity: POL = 1, PERIOD = 6, HIGH = 2, COUNT = 1 -> sma_out idles at 1, pulses low for 2 clocks, and returns to 1.
- DONE clear race: write STATUS = 0x2 on the completion cycle -> DONE reads 1. A later W1C write clears it and irq deasserts the next cycle.

Source files
------------

// File: rtl/de2_115_sma_pulse_gen.sv
// Avalon-MM programmable pulse-train generator driving the SMA connector pin.
// readdata is zero-latency combinational; sma_out is registered; the slave never stalls (zero wait states).
module de2_115_sma_pulse_gen #(
    parameter int CNT_W  = 32,
    parameter int PCNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        sma_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_cont;
    logic               r_pol;
    logic               r_irq_en;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_high;
    logic [PCNT_W-1:0]  r_count;
    logic               r_done;
    logic [CNT_W-1:0]   r_phase;
    logic [CNT_W-1:0]   r_per_sh;
    logic [CNT_W-1:0]   r_high_sh;
    logic [PCNT_W-1:0]  r_pcnt;
    logic               r_sma;

    logic               w_wr;
    logic               w_wr_ctrl;
    logic               w_wr_status;
    logic               w_pol_nxt;
    logic               w_busy;
    logic [CNT_W-1:0]   w_eff_per;
    logic               w_wrap;
    logic [CNT_W-1:0]   w_phase_nxt;
    logic [CNT_W-1:0]   w_per_sh_nxt;
    logic [CNT_W-1:0]   w_high_sh_nxt;
    logic [PCNT_W-1:0]  w_pcnt_nxt;
    logic               w_done_nxt;
    logic               w_sma_nxt;

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_ctrl   = w_wr && (address == 3'd0);
    assign w_wr_status = w_wr && (address == 3'd4);
    assign w_pol_nxt   = w_wr_ctrl ? writedata[2] : r_pol;
    assign w_busy      = (r_state == ST_RUN);

    // Periods below 2 are clamped so the phase counter always has a low phase to wrap through.
    assign w_eff_per = (r_per_sh < CNT_W'(2)) ? CNT_W'(2) : r_per_sh;
    assign w_wrap    = (r_phase == (w_eff_per - CNT_W'(1)));

    // CPU-visible configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cont   <= 1'b0;
            r_pol    <= 1'b0;
            r_irq_en <= 1'b0;
            r_period <= '0;
            r_high   <= '0;
            r_count  <= '0;
        end else if (w_wr) begin
            case (address)
                3'd0: begin
                    r_cont   <= writedata[1];
                    r_pol    <= writedata[2];
                    r_irq_en <= writedata[3];
                end
                3'd1:    r_period <= writedata[CNT_W-1:0];
                3'd2:    r_high   <= writedata[CNT_W-1:0];
                3'd3:    r_count  <= writedata[PCNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_per_sh  <= '0;
            r_high_sh <= '0;
            r_pcnt    <= '0;
            r_done    <= 1'b0;
            r_sma     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_per_sh  <= w_per_sh_nxt;
            r_high_sh <= w_high_sh_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_done    <= w_done_nxt;
            r_sma     <= w_sma_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_per_sh_nxt  = r_per_sh;
        w_high_sh_nxt = r_high_sh;
        w_pcnt_nxt    = r_pcnt;
        // A completion below overrides this clear when both land on the same edge.
        w_done_nxt    = r_done & ~(w_wr_status & writedata[1]);

        case (r_state)
            ST_IDLE: begin
                if (w_wr_ctrl && writedata[0]) begin
                    if (!writedata[1] && (r_count == '0)) begin
                        w_done_nxt = 1'b1;
                        w_pcnt_nxt = '0;
                    end else begin
                        w_state_nxt   = ST_RUN;
                        w_phase_nxt   = '0;
                        w_per_sh_nxt  = r_period;
                        w_high_sh_nxt = r_high;
                        w_pcnt_nxt    = r_count;
                    end
                end
            end
            ST_RUN: begin
                if (w_wr_ctrl && !writedata[0]) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_wrap) begin
                    w_phase_nxt   = '0;
                    w_per_sh_nxt  = r_period;
                    w_high_sh_nxt = r_high;
                    if (!r_cont) begin
                        w_pcnt_nxt = r_pcnt - PCNT_W'(1);
                        if (r_pcnt <= PCNT_W'(1)) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                            w_pcnt_nxt  = '0;
                        end
                    end
                end else begin
                    w_phase_nxt = r_phase + CNT_W'(1);
                end
            end
        endcase

        // Output is computed from the next state so it lines up with the phase it describes.
        w_sma_nxt = w_pol_nxt ^ ((w_state_nxt == ST_RUN) && (w_phase_nxt < w_high_sh_nxt));
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata[3:0] = {r_irq_en, r_pol, r_cont, w_busy};
            3'd1:    readdata[CNT_W-1:0] = r_period;
            3'd2:    readdata[CNT_W-1:0] = r_high;
            3'd3:    readdata[PCNT_W-1:0] = r_count;
            3'd4: begin
                readdata[16 +: PCNT_W] = r_pcnt;
                readdata[1]            = r_done;
                readdata[0]            = w_busy;
            end
            default: ;
        endcase
    end

    assign irq     = r_done & r_irq_en;
    assign sma_out = r_sma;

endmodule

// File: tb/tb_de2_115_sma_pulse_gen.sv
// Randomized bench for the SMA pulse generator against a per-cycle expected-waveform model.
module tb_de2_115_sma_pulse_gen;

    localparam int MAXC = 6000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        sma_out;

    always #5 clk = ~clk;

    de2_115_sma_pulse_gen #(.CNT_W(32), .PCNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .sma_out    (sma_out)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Expected outputs per cycle index (cycle n = interval after the n-th rising edge).
    logic        exp_sma  [MAXC];
    logic        exp_irq  [MAXC];
    logic [31:0] exp_stat [MAXC];

    logic m_pol, m_irq_en, m_done;
    int   m_rem, m_count;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got 0x%08h want 0x%08h", nm, cyc, act, exp);
        end
    endtask

    function automatic void paint_idle(input int from);
        for (int c = from; c < MAXC; c++) begin
            exp_sma[c]  = m_pol;
            exp_irq[c]  = m_done & m_irq_en;
            exp_stat[c] = {16'(m_rem), 14'd0, m_done, 1'b0};
        end
    endfunction

    function automatic int eff_of(input int per);
        return (per < 2) ? 2 : per;
    endfunction

    // One-shot run: cnt pulses of eff cycles each, active while the index within the pulse < hi.
    function automatic int paint_run(input int w, input int cnt, input int per, input int hi);
        int eff = eff_of(per);
        for (int k = 0; k < cnt; k++) begin
            for (int j = 0; j < eff; j++) begin
                int c = w + k * eff + j;
                if (c < MAXC) begin
                    exp_sma[c]  = m_pol ^ (j < hi);
                    exp_irq[c]  = m_done & m_irq_en;
                    exp_stat[c] = {16'(cnt - k), 14'd0, m_done, 1'b1};
                end
            end
        end
        return w + cnt * eff;
    endfunction

    function automatic void paint_cont(input int w, input int per, input int hi);
        int eff = eff_of(per);
        for (int c = w; c < MAXC; c++) begin
            exp_sma[c]  = m_pol ^ (((c - w) % eff) < hi);
            exp_irq[c]  = m_done & m_irq_en;
            exp_stat[c] = {16'(m_count), 14'd0, m_done, 1'b1};
        end
    endfunction

    always @(negedge clk) begin
        if (chk_on && reset_n && cyc < MAXC) begin
            chk("sma_out", {31'd0, sma_out}, {31'd0, exp_sma[cyc]});
            chk("irq", {31'd0, irq}, {31'd0, exp_irq[cyc]});
            if (!chipselect && address == 3'd4)
                chk("status", readdata, exp_stat[cyc]);
        end
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, output int e);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        e = cyc;
        chipselect = 1'b0; write_n = 1'b1; address = 3'd4; writedata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin @(posedge clk); #1; end
    endtask

    task automatic cfg(input int per, input int hi, input int cnt);
        int e;
        bus_wr(3'd1, 32'(per), e);
        bus_wr(3'd2, 32'(hi), e);
        bus_wr(3'd3, 32'(cnt), e);
        m_count = cnt;
    endtask

    task automatic start_os(input int per, input int hi, input int cnt, input bit pol, input bit ien,
                            output int w, output int endc);
        m_pol = pol; m_irq_en = ien;
        bus_wr(3'd0, {28'd0, ien, pol, 1'b0, 1'b1}, w);
        if (cnt == 0) endc = w;
        else          endc = paint_run(w, cnt, per, hi);
        m_done = 1'b1; m_rem = 0;
        paint_idle(endc);
    endtask

    task automatic clear_done(output int e);
        bus_wr(3'd4, 32'h2, e);
        m_done = 1'b0;
        paint_idle(e);
    endtask

    initial begin
        int w, endc, e, s, per, hi, cnt, eff;
        bit pol, ien;
        reset_n = 1'b0; address = 3'd4; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        m_pol = 0; m_irq_en = 0; m_done = 0; m_rem = 0; m_count = 0;
        paint_idle(0);
        idle(3);
        chk("rst_sma", {31'd0, sma_out}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a); #1;
            chk("rst_rd", readdata, 32'd0);
        end
        address = 3'd4;
        reset_n = 1'b1;
        paint_idle(cyc);
        chk_on = 1'b1;
        idle(2);

        // One-shot 10/3 x4, IRQ enabled.
        cfg(10, 3, 4);
        start_os(10, 3, 4, 1'b0, 1'b1, w, endc);
        #1 chk("os_first_high", {31'd0, sma_out}, 32'd1);
        wait_to(w + 3);  #1 chk("os_first_low", {31'd0, sma_out}, 32'd0);
        wait_to(w + 39); #1 chk("os_last_busy", readdata, 32'h0001_0001);
        wait_to(w + 40); #1 chk("os_done_stat", readdata, 32'h0000_0002);
        chk("os_irq", {31'd0, irq}, 32'd1);
        idle(1); clear_done(e);

        // Continuous 4/2 with PERIOD raised to 8 mid-pulse, then stop during a high phase.
        cfg(4, 2, 7);
        m_pol = 0; m_irq_en = 0;
        bus_wr(3'd0, 32'h3, w);
        paint_cont(w, 4, 2);
        paint_cont(w + 8, 8, 2);
        #1 chk("cont_high0", {31'd0, sma_out}, 32'd1);
        wait_to(w + 2);  #1 chk("cont_low0", {31'd0, sma_out}, 32'd0);
        wait_to(w + 4);  #1 chk("cont_high1", {31'd0, sma_out}, 32'd1);
        bus_wr(3'd1, 32'd8, e);
        wait_to(w + 8);  #1 chk("cont_high2", {31'd0, sma_out}, 32'd1);
        wait_to(w + 10); #1 chk("cont_low2", {31'd0, sma_out}, 32'd0);
        wait_to(w + 16); #1 chk("cont_high3", {31'd0, sma_out}, 32'd1);
        wait_to(w + 24);
        bus_wr(3'd0, 32'h0, s);
        m_rem = 7; paint_idle(s);
        #1 chk("stop_sma", {31'd0, sma_out}, 32'd0);
        chk("stop_stat", readdata, 32'h0007_0000);
        idle(3);

        // PERIOD 0 is clamped to 2.
        cfg(0, 1, 3);
        start_os(0, 1, 3, 1'b0, 1'b0, w, endc);
        #1 chk("p0_h", {31'd0, sma_out}, 32'd1);
        wait_to(w + 1); #1 chk("p0_l", {31'd0, sma_out}, 32'd0);
        wait_to(w + 2); #1 chk("p0_h2", {31'd0, sma_out}, 32'd1);
        wait_to(endc); clear_done(e);

        cfg(7, 0, 2);
        start_os(7, 0, 2, 1'b0, 1'b0, w, endc);
        #1 chk("h0_low", {31'd0, sma_out}, 32'd0);
        wait_to(endc); clear_done(e);

        cfg(5, 20, 2);
        start_os(5, 20, 2, 1'b0, 1'b0, w, endc);
        wait_to(w + 9);  #1 chk("hbig_high", {31'd0, sma_out}, 32'd1);
        chk("hbig_busy", readdata, 32'h0001_0001);
        wait_to(w + 10); #1 chk("hbig_end", {31'd0, sma_out}, 32'd0);
        clear_done(e);

        cfg(5, 2, 0);
        start_os(5, 2, 0, 1'b0, 1'b0, w, endc);
        #1 chk("c0_stat", readdata, 32'h0000_0002);
        chk("c0_sma", {31'd0, sma_out}, 32'd0);
        idle(1); clear_done(e);

        // Inverted polarity.
        bus_wr(3'd0, 32'h4, e);
        m_pol = 1; paint_idle(e);
        #1 chk("pol_idle", {31'd0, sma_out}, 32'd1);
        cfg(6, 2, 1);
        start_os(6, 2, 1, 1'b1, 1'b0, w, endc);
        #1 chk("pol_low0", {31'd0, sma_out}, 32'd0);
        wait_to(w + 1); #1 chk("pol_low1", {31'd0, sma_out}, 32'd0);
        wait_to(w + 2); #1 chk("pol_back", {31'd0, sma_out}, 32'd1);
        wait_to(endc);  #1 chk("pol_end", {31'd0, sma_out}, 32'd1);
        clear_done(e);

        // DONE clear on the completion edge: set wins.
        cfg(5, 2, 2);
        start_os(5, 2, 2, 1'b0, 1'b1, w, endc);
        wait_to(endc - 1);
        bus_wr(3'd4, 32'h2, e);
        #1 chk("race_done", {31'd0, readdata[1]}, 32'd1);
        chk("race_irq", {31'd0, irq}, 32'd1);
        idle(2);
        clear_done(e);
        #1 chk("w1c_irq", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            per = int'($urandom_range(0, 12));
            hi  = int'($urandom_range(0, 14));
            cnt = int'($urandom_range(0, 5));
            pol = 1'($urandom_range(0, 1));
            ien = 1'($urandom_range(0, 1));
            eff = eff_of(per);
            cfg(per, hi, cnt);
            start_os(per, hi, cnt, pol, ien, w, endc);
            if (cnt != 0 && $urandom_range(0, 3) == 0) begin
                s = w + 1 + int'($urandom_range(0, cnt * eff - 1));
                wait_to(s - 1);
                bus_wr(3'd0, {28'd0, ien, pol, 2'b00}, e);
                m_done = 1'b0;
                m_rem  = cnt - (e - 1 - w) / eff;
                paint_idle(e);
            end else begin
                wait_to(endc);
            end
            idle(int'($urandom_range(0, 3)));
            clear_done(e);
        end

        // Reset in the middle of an inverted continuous run.
        cfg(5, 0, 1);
        m_pol = 1; m_irq_en = 1;
        bus_wr(3'd0, 32'hF, w);
        paint_cont(w, 5, 0);
        idle(3);
        #1 chk("mrst_pre", {31'd0, sma_out}, 32'd1);
        chk_on = 1'b0;
        reset_n = 1'b0;
        #1 chk("mrst_sma", {31'd0, sma_out}, 32'd0);
        chk("mrst_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a); #1;
            chk("mrst_rd", readdata, 32'd0);
        end
        address = 3'd4;
        idle(1);
        reset_n = 1'b1;
        m_pol = 0; m_irq_en = 0; m_done = 0; m_rem = 0; m_count = 0;
        paint_idle(cyc);
        chk_on = 1'b1;
        idle(3);
        #1 chk("post_rst_stat", readdata, 32'd0);
        chk("post_rst_sma", {31'd0, sma_out}, 32'd0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
